ca_search_scheduler: RTL and testbench

Acquisition search controller that owns the C/A code generator during a cold search. For every enabled PRN and every code-phase bin it resets the generator, slews it to the bin's phase, runs one correlator dwell, and keeps the strongest result. At the end of the sweep it reports the best PRN, phase and energy, plus a found flag against a programmable threshold. It sits between the acquisition front-end control and the generator/correlator pair.

---
 rtl/ca_search_scheduler_pkg.sv | 18 +
 rtl/ca_prn_mask_scan.sv | 23 ++
 rtl/ca_search_scheduler.sv | 147 ++++++++++++++
 tb/tb_ca_search_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_search_scheduler_pkg.sv
// Shared acquisition definitions: scheduler state encoding and C/A code geometry.
package ca_search_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LOAD,
    ST_SLEW,
    ST_DWELL,
    ST_EVAL,
    ST_FINISH
  } state_t;

  localparam int CA_CODE_LEN   = 1023;
  localparam int CA_LAST_PHASE = 1022;
  localparam int NUM_PRN       = 32;

endpackage

// File: rtl/ca_prn_mask_scan.sv
// Combinational priority finder: lowest set mask bit at or above a start index.
module ca_prn_mask_scan
  import ca_search_scheduler_pkg::*;
(
  input  logic [NUM_PRN-1:0] mask,
  input  logic [4:0]         from,
  output logic [4:0]         idx,
  output logic               none
);

  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = NUM_PRN - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        idx  = 5'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ca_search_scheduler.sv
// Cold-search controller: sweeps enabled PRNs and code-phase bins, keeps the strongest dwell.
module ca_search_scheduler
  import ca_search_scheduler_pkg::*;
#(
  parameter int PHASE_STEP   = 1,
  parameter int ENERGY_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             sat_mask,
  input  logic [ENERGY_WIDTH-1:0] threshold,
  input  logic                    chip_tick,
  input  logic [9:0]              ca_code_shift,
  output logic [4:0]              ca_prn,
  output logic                    ca_reset,
  output logic                    ca_enable,
  output logic                    dwell_start,
  input  logic                    dwell_done,
  input  logic [ENERGY_WIDTH-1:0] dwell_energy,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [4:0]              best_prn,
  output logic [9:0]              best_phase,
  output logic [ENERGY_WIDTH-1:0] best_energy
);

  localparam logic [10:0] STEP = 11'(PHASE_STEP);

  state_t                    state, state_nx;
  logic [NUM_PRN-1:0]        mask_r;
  logic [ENERGY_WIDTH-1:0]   thr_r;
  logic [ENERGY_WIDTH-1:0]   energy_r;
  logic [4:0]                prn;
  logic [9:0]                phase;
  logic                      first;
  logic [4:0]                scan_idx;
  logic                      scan_none;
  logic [10:0]               phase_sum;
  logic                      wrap;
  logic                      take_best;
  logic                      result_ok;
  logic [ENERGY_WIDTH-1:0]   best_e_nx;

  ca_prn_mask_scan u_scan (
    .mask (mask_r),
    .from (prn),
    .idx  (scan_idx),
    .none (scan_none)
  );

  assign ca_prn = prn;

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_SELECT;
      ST_SELECT: state_nx = scan_none ? ST_FINISH : ST_LOAD;
      ST_LOAD:   state_nx = ST_SLEW;
      ST_SLEW:   if (ca_code_shift == phase) state_nx = ST_DWELL;
      ST_DWELL:  if (dwell_done && !dwell_start) state_nx = ST_EVAL;
      ST_EVAL: begin
        if (wrap) state_nx = (prn == 5'(NUM_PRN - 1)) ? ST_FINISH : ST_SELECT;
        else      state_nx = ST_LOAD;
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  // Output and datapath decode; ca_enable is the only combinational output.
  always_comb begin
    phase_sum = {1'b0, phase} + STEP;
    wrap      = phase_sum > 11'(CA_LAST_PHASE);
    take_best = (state == ST_EVAL) && (first || (energy_r > best_energy));
    best_e_nx = take_best ? energy_r : best_energy;
    result_ok = ((state == ST_EVAL) || !first) && (best_e_nx >= thr_r);
    ca_enable = 1'b0;
    if (state == ST_SLEW)  ca_enable = (ca_code_shift != phase);
    if (state == ST_DWELL) ca_enable = chip_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      mask_r      <= '0;
      thr_r       <= '0;
      energy_r    <= '0;
      prn         <= '0;
      phase       <= '0;
      first       <= 1'b1;
      ca_reset    <= 1'b1;
      dwell_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      best_prn    <= '0;
      best_phase  <= '0;
      best_energy <= '0;
    end else begin
      state       <= state_nx;
      ca_reset    <= (state_nx == ST_LOAD);
      dwell_start <= (state_nx == ST_DWELL) && (state != ST_DWELL);
      busy        <= (state_nx != ST_IDLE);
      done        <= (state_nx == ST_FINISH);
      if (state_nx == ST_FINISH) found <= result_ok;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            mask_r      <= sat_mask;
            thr_r       <= threshold;
            prn         <= '0;
            phase       <= '0;
            first       <= 1'b1;
            found       <= 1'b0;
            best_prn    <= '0;
            best_phase  <= '0;
            best_energy <= '0;
          end
        end
        ST_SELECT: if (!scan_none) prn <= scan_idx;
        ST_DWELL:  if (dwell_done && !dwell_start) energy_r <= dwell_energy;
        ST_EVAL: begin
          // Strict compare keeps the earlier bin on ties.
          if (take_best) begin
            best_prn    <= prn;
            best_phase  <= phase;
            best_energy <= energy_r;
          end
          first <= 1'b0;
          if (wrap) begin
            phase <= '0;
            if (prn != 5'(NUM_PRN - 1)) prn <= prn + 5'd1;
          end else begin
            phase <= phase_sum[9:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_search_scheduler.sv
// Randomized bench for ca_search_scheduler with generator/correlator models and a sweep reference model.
module tb_ca_search_scheduler;

  localparam int STEP = 511;
  localparam int EW   = 24;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [31:0]   sat_mask;
  logic [EW-1:0] threshold;
  logic          chip_tick = 1'b0;
  logic [9:0]    ca_code_shift = '0;
  logic [4:0]    ca_prn;
  logic          ca_reset, ca_enable, dwell_start;
  logic          dwell_done = 1'b0;
  logic [EW-1:0] dwell_energy = '0;
  logic          busy, done, found;
  logic [4:0]    best_prn;
  logic [9:0]    best_phase;
  logic [EW-1:0] best_energy;

  always #5 clk = ~clk;

  ca_search_scheduler #(.PHASE_STEP(STEP), .ENERGY_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sat_mask(sat_mask), .threshold(threshold), .chip_tick(chip_tick),
    .ca_code_shift(ca_code_shift), .ca_prn(ca_prn), .ca_reset(ca_reset),
    .ca_enable(ca_enable), .dwell_start(dwell_start), .dwell_done(dwell_done),
    .dwell_energy(dwell_energy), .busy(busy), .done(done), .found(found),
    .best_prn(best_prn), .best_phase(best_phase), .best_energy(best_energy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] tab [0:95];
  int dw_prn[$], dw_ph[$], dw_en[$], load_prn[$];
  int done_cnt = 0;
  int en_cnt   = 0;
  bit corr_stall = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Generator model: code phase counter, cleared by ca_reset, advanced by ca_enable.
  always @(posedge clk) begin
    if (ca_reset) ca_code_shift <= '0;
    else if (ca_enable) ca_code_shift <= (ca_code_shift == 10'd1022) ? 10'd0 : ca_code_shift + 10'd1;
    chip_tick <= 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dwell_start) begin
      dw_prn.push_back(int'(ca_prn));
      dw_ph.push_back(int'(ca_code_shift));
      dw_en.push_back(en_cnt);
    end
    if (ca_reset && busy) load_prn.push_back(int'(ca_prn));
    if (ca_reset) en_cnt = 0;
    else if (ca_enable) en_cnt++;
  end

  // Correlator model: spurious result in the start cycle, real result 1..4 cycles later.
  always begin
    int idx, lat, k;
    bit drop;
    @(negedge clk);
    dwell_done = 1'b0;
    if (dwell_start) begin
      idx = int'(ca_prn) * 3 + int'(ca_code_shift) / STEP;
      if ($urandom_range(0, 1) == 1) begin
        dwell_done   = 1'b1;
        dwell_energy = 24'hFFFFFF;
      end
      lat  = int'($urandom_range(1, 4));
      k    = 0;
      drop = 1'b0;
      while ((k < lat) || corr_stall) begin
        @(negedge clk);
        dwell_done = 1'b0;
        k++;
        if (!busy) begin
          drop = 1'b1;
          break;
        end
      end
      if (!drop) begin
        dwell_done   = 1'b1;
        dwell_energy = tab[idx];
      end
    end
  end

  task automatic clear_logs();
    dw_prn.delete(); dw_ph.delete(); dw_en.delete(); load_prn.delete();
  endtask

  task automatic run_sweep(input logic [31:0] m, input logic [EW-1:0] t, input string tag);
    int ep[$], eph[$];
    int bp, bph, cyc;
    logic [EW-1:0] be, e;
    bit bf, first, got;
    first = 1'b1; bp = 0; bph = 0; be = '0;
    for (int p = 0; p < 32; p++) begin
      if (m[p]) begin
        for (int ph = 0; ph <= 1022; ph += STEP) begin
          ep.push_back(p);
          eph.push_back(ph);
          e = tab[p * 3 + ph / STEP];
          if (first || (e > be)) begin
            bp = p; bph = ph; be = e;
          end
          first = 1'b0;
        end
      end
    end
    bf = !first && (be >= t);

    clear_logs();
    sat_mask = m; threshold = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sat_mask = $urandom; threshold = EW'($urandom);
    check_eq({tag, "_busy"}, busy, 1);
    got = 1'b0;
    for (cyc = 1; cyc < 40000; cyc++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_done"}, got, 1);
    if (m == 0) check_eq({tag, "_latency_le3"}, cyc <= 3, 1);
    check_eq({tag, "_best_prn"}, best_prn, bp);
    check_eq({tag, "_best_phase"}, best_phase, bph);
    check_eq({tag, "_best_energy"}, best_energy, be);
    check_eq({tag, "_found"}, found, bf);
    check_eq({tag, "_ndwell"}, dw_prn.size(), ep.size());
    check_eq({tag, "_nload"}, load_prn.size(), ep.size());
    if (dw_prn.size() == ep.size() && load_prn.size() == ep.size()) begin
      for (int i = 0; i < ep.size(); i++) begin
        check_eq({tag, "_dwell_prn"}, dw_prn[i], ep[i]);
        check_eq({tag, "_dwell_shift"}, dw_ph[i], eph[i]);
        check_eq({tag, "_slew_enables"}, dw_en[i], eph[i]);
        check_eq({tag, "_load_prn"}, load_prn[i], ep[i]);
      end
    end
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, done, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_found_held"}, found, bf);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;
    int dc, w;
    reset = 1'b1; start = 1'b0; abort = 1'b0; sat_mask = '0; threshold = '0;
    for (int i = 0; i < 96; i++) tab[i] = EW'($urandom_range(0, 999));
    repeat (3) @(negedge clk);
    check_eq("rst_ca_reset", ca_reset, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dwell_start", dwell_start, 0);
    check_eq("rst_best_energy", best_energy, 0);
    check_eq("rst_found", found, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_ca_reset", ca_reset, 0);
    check_eq("idle_ca_enable", ca_enable, 0);

    tab[0] = 100; tab[1] = 900; tab[2] = 50;
    run_sweep(32'h1, 900, "basic_thr900");
    run_sweep(32'h1, 901, "basic_thr901");
    run_sweep(32'h0, 0, "empty_mask");
    run_sweep(32'h8000_0001, EW'($urandom_range(0, 999)), "edges");
    tab[15] = 200; tab[16] = 300; tab[17] = 300;
    run_sweep(32'h20, 300, "tie");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 96; i++) tab[i] = EW'($urandom_range(0, 7));
      m = '0;
      repeat ($urandom_range(1, 3)) m[$urandom_range(0, 31)] = 1'b1;
      run_sweep(m, EW'($urandom_range(0, 8)), "rand");
    end

    // start with abort in the same cycle
    start = 1'b1; abort = 1'b1; sat_mask = 32'h1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);

    // abort while a dwell is outstanding
    clear_logs();
    corr_stall = 1'b1;
    start = 1'b1; sat_mask = 32'h1; threshold = 0;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (dw_prn.size() == 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("abort_reach_dwell", dw_prn.size() > 0, 1);
    @(negedge clk);
    dc = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    check_eq("abort_no_done", done_cnt, dc);
    corr_stall = 1'b0;
    run_sweep(32'h1, 50, "after_abort");

    // reset while slewing to the second bin
    clear_logs();
    tab[3] = 77;
    start = 1'b1; sat_mask = 32'h2; threshold = 0;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (load_prn.size() < 2 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_eq("rstslew_reach_load2", load_prn.size() >= 2, 1);
    repeat (20) @(negedge clk);
    check_eq("rstslew_partial_best", best_energy, 77);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rstslew_busy", busy, 0);
    check_eq("rstslew_ca_reset", ca_reset, 1);
    check_eq("rstslew_best_cleared", best_energy, 0);
    @(negedge clk);
    check_eq("rstslew_ca_reset_rel", ca_reset, 0);
    repeat (5) @(negedge clk);
    check_eq("rstslew_no_done", done_cnt, dc);
    run_sweep(32'h0000_0402, 10, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
